// File: rtl/sobel_edge_3x3.sv
`default_nettype none
// ============================================================================
// Module      : sobel_edge_3x3
// Description : 3-stage Sobel L1 gradient, saturation and threshold, with
//               per-frame threshold shadowing and edge-pixel accounting.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_edge_3x3 #(
    parameter  int DATA_W        = 8,
    parameter  int OUT_PER_FRAME = 304964,
    parameter  int THRESH_DEF    = 128,
    localparam int MAG_W         = DATA_W + 3,
    localparam int CNT_W         = $clog2(OUT_PER_FRAME + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] w00,
    input  logic [DATA_W-1:0] w01,
    input  logic [DATA_W-1:0] w02,
    input  logic [DATA_W-1:0] w10,
    input  logic [DATA_W-1:0] w11,
    input  logic [DATA_W-1:0] w12,
    input  logic [DATA_W-1:0] w20,
    input  logic [DATA_W-1:0] w21,
    input  logic [DATA_W-1:0] w22,
    input  logic [MAG_W-1:0]  thresh_in,
    output logic [MAG_W-1:0]  mag_out,
    output logic [DATA_W-1:0] pix_out,
    output logic              edge_out,
    output logic              valid_out,
    output logic              frame_done,
    output logic [CNT_W-1:0]  edge_count
);

    localparam int              PS_W      = DATA_W + 2;
    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(OUT_PER_FRAME - 1);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
    localparam logic [MAG_W-1:0] c_PIX_MAX = MAG_W'((1 << DATA_W) - 1);

    // the centre pixel does not contribute to either Sobel kernel
    logic w_unused_center;
    assign w_unused_center = ^w11;

    logic              r_v1, r_v2, r_v3;
    logic [PS_W-1:0]   r_xp, r_xn, r_yp, r_yn;
    logic [PS_W-1:0]   r_ax, r_ay;
    logic [MAG_W-1:0]  r_thr1, r_thr2, r_thr_act;
    logic [MAG_W-1:0]  r_mag;
    logic [DATA_W-1:0] r_pix;
    logic              r_edge;
    logic              r_frame_done;
    logic [CNT_W-1:0]  r_in_idx, r_out_idx, r_acc, r_edge_count;

    logic [PS_W-1:0]          w_xp, w_xn, w_yp, w_yn;
    logic signed [DATA_W+2:0] w_gx, w_gy;
    logic [PS_W-1:0]          w_ax, w_ay;
    logic [MAG_W-1:0]         w_mag, w_thr_win;
    logic [DATA_W-1:0]        w_pix;
    logic [CNT_W-1:0]         w_acc_next;

    assign w_xp = {2'b00, w02} + {1'b0, w12, 1'b0} + {2'b00, w22};
    assign w_xn = {2'b00, w00} + {1'b0, w10, 1'b0} + {2'b00, w20};
    assign w_yp = {2'b00, w20} + {1'b0, w21, 1'b0} + {2'b00, w22};
    assign w_yn = {2'b00, w00} + {1'b0, w01, 1'b0} + {2'b00, w02};

    assign w_gx = $signed({1'b0, r_xp}) - $signed({1'b0, r_xn});
    assign w_gy = $signed({1'b0, r_yp}) - $signed({1'b0, r_yn});
    assign w_ax = w_gx[DATA_W+2] ? PS_W'(-w_gx) : PS_W'(w_gx);
    assign w_ay = w_gy[DATA_W+2] ? PS_W'(-w_gy) : PS_W'(w_gy);

    assign w_mag = {1'b0, r_ax} + {1'b0, r_ay};
    assign w_pix = (w_mag > c_PIX_MAX) ? {DATA_W{1'b1}} : w_mag[DATA_W-1:0];

    // window 0 of a frame uses the freshly loaded threshold, not the old one
    assign w_thr_win  = (r_in_idx == '0) ? thresh_in : r_thr_act;
    assign w_acc_next = r_acc + {{(CNT_W-1){1'b0}}, r_edge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            r_xp      <= '0;
            r_xn      <= '0;
            r_yp      <= '0;
            r_yn      <= '0;
            r_ax      <= '0;
            r_ay      <= '0;
            r_thr1    <= '0;
            r_thr2    <= '0;
            r_thr_act <= MAG_W'(THRESH_DEF);
            r_mag     <= '0;
            r_pix     <= '0;
            r_edge    <= 1'b0;
            r_in_idx  <= '0;
        end else begin
            r_v1 <= valid_in;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (valid_in) begin
                r_xp   <= w_xp;
                r_xn   <= w_xn;
                r_yp   <= w_yp;
                r_yn   <= w_yn;
                r_thr1 <= w_thr_win;
                if (r_in_idx == '0) begin
                    r_thr_act <= thresh_in;
                end
                r_in_idx <= (r_in_idx == c_LAST) ? '0 : r_in_idx + c_ONE;
            end
            if (r_v1) begin
                r_ax   <= w_ax;
                r_ay   <= w_ay;
                r_thr2 <= r_thr1;
            end
            if (r_v2) begin
                r_mag  <= w_mag;
                r_pix  <= w_pix;
                r_edge <= (w_mag > r_thr2);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_idx    <= '0;
            r_acc        <= '0;
            r_edge_count <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_v3) begin
                if (r_out_idx == c_LAST) begin
                    r_out_idx    <= '0;
                    r_acc        <= '0;
                    r_edge_count <= w_acc_next;
                    r_frame_done <= 1'b1;
                end else begin
                    r_out_idx <= r_out_idx + c_ONE;
                    r_acc     <= w_acc_next;
                end
            end
        end
    end

    assign mag_out    = r_mag;
    assign pix_out    = r_pix;
    assign edge_out   = r_edge;
    assign valid_out  = r_v3;
    assign frame_done = r_frame_done;
    assign edge_count = r_edge_count;

endmodule
`default_nettype wire

// File: tb/tb_sobel_edge_3x3.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_edge_3x3
// Description : Table-driven and scoreboard bench for sobel_edge_3x3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_edge_3x3;

    localparam int DW  = 8;
    localparam int OPF = 4;
    localparam int MW  = DW + 3;
    localparam int CW  = $clog2(OPF + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
    logic [MW-1:0] thresh_in;
    logic [MW-1:0] mag_out;
    logic [DW-1:0] pix_out;
    logic          edge_out, valid_out, frame_done;
    logic [CW-1:0] edge_count;

    sobel_edge_3x3 #(.DATA_W(DW), .OUT_PER_FRAME(OPF), .THRESH_DEF(128)) u_dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .w00(w00), .w01(w01), .w02(w02),
        .w10(w10), .w11(w11), .w12(w12),
        .w20(w20), .w21(w21), .w22(w22),
        .thresh_in(thresh_in),
        .mag_out(mag_out), .pix_out(pix_out), .edge_out(edge_out),
        .valid_out(valid_out), .frame_done(frame_done), .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] px;
        int thr;
        int mag;
        int pix;
        int edg;
    } vec_t;

    typedef struct {
        int mag;
        int pix;
        int edg;
        int last;
        int cnt;
        int stamp;
    } exp_t;

    exp_t q[$];
    vec_t tbl[10];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_idx = 0;
    int m_acc = 0;
    int m_thr = 128;
    int pend = 0;
    int pend_cnt = 0;
    int exp_ec = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    function automatic logic [71:0] pk(input int a00, a01, a02, a10, a11, a12, a20, a21, a22);
        return {a22[7:0], a21[7:0], a20[7:0], a12[7:0], a11[7:0], a10[7:0],
                a02[7:0], a01[7:0], a00[7:0]};
    endfunction

    function automatic void model(input logic [71:0] px, input int thr,
                                  output int mag, output int pix, output int edg);
        int p[9];
        int gx, gy;
        for (int i = 0; i < 9; i++) p[i] = int'(px[8*i +: 8]);
        gx  = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy  = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        pix = (mag > 255) ? 255 : mag;
        edg = (mag > thr) ? 1 : 0;
    endfunction

    task automatic drive(input logic [71:0] px, input int thr, input int mag,
                         input int pix, input int edg, input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        valid_in  = 1'b1;
        w00 = px[7:0];   w01 = px[15:8];  w02 = px[23:16];
        w10 = px[31:24]; w11 = px[39:32]; w12 = px[47:40];
        w20 = px[55:48]; w21 = px[63:56]; w22 = px[71:64];
        thresh_in = thr[MW-1:0];
        if (m_idx == 0) m_thr = thr;
        if (push) begin
            e.mag   = mag;
            e.pix   = pix;
            e.edg   = edg;
            e.last  = (m_idx == OPF-1) ? 1 : 0;
            e.cnt   = m_acc + edg;
            e.stamp = cyc + 3;
            q.push_back(e);
        end
        if (m_idx == OPF-1) begin
            m_idx = 0;
            m_acc = 0;
        end else begin
            m_idx++;
            m_acc += edg;
        end
    endtask

    task automatic drive_m(input logic [71:0] px, input int thr);
        int teff, mag, pix, edg;
        teff = (m_idx == 0) ? thr : m_thr;
        model(px, teff, mag, pix, edg);
        drive(px, thr, mag, pix, edg, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid_out"}, int'(valid_out), 0);
        chk({tag, "_mag_out"}, int'(mag_out), 0);
        chk({tag, "_pix_out"}, int'(pix_out), 0);
        chk({tag, "_edge_out"}, int'(edge_out), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_edge_count"}, int'(edge_count), 0);
    endtask

    // scoreboard / frame monitor; frame_done and edge_count trail the last pixel by one cycle
    always @(negedge clk) begin
        exp_t it;
        if (!rst_n) begin
            pend   = 0;
            exp_ec = 0;
        end else begin
            chk("frame_done", int'(frame_done), pend);
            if (pend != 0) exp_ec = pend_cnt;
            chk("edge_count", int'(edge_count), exp_ec);
            pend = 0;
            if (valid_out) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid_out", 1, 0);
                end else begin
                    it = q.pop_front();
                    chk("latency", cyc, it.stamp);
                    chk("mag_out", int'(mag_out), it.mag);
                    chk("pix_out", int'(pix_out), it.pix);
                    chk("edge_out", int'(edge_out), it.edg);
                    pend     = it.last;
                    pend_cnt = it.cnt;
                end
            end
        end
    end

    initial begin
        logic [71:0] v_px, f_px;
        v_px = pk(0, 255, 255, 0, 255, 255, 0, 255, 255);
        f_px = pk(100, 100, 100, 100, 100, 100, 100, 100, 100);
        tbl[0] = '{f_px, 128, 0, 0, 0};
        tbl[1] = '{v_px, 128, 1020, 255, 1};
        tbl[2] = '{pk(0, 0, 0, 0, 0, 64, 0, 0, 0), 128, 128, 128, 0};
        tbl[3] = '{pk(0, 0, 0, 0, 0, 64, 0, 0, 0), 127, 128, 128, 1};
        tbl[4] = '{pk(200, 200, 200, 0, 0, 0, 0, 0, 0), 128, 800, 255, 1};
        tbl[5] = '{pk(255, 0, 0, 0, 0, 0, 0, 0, 0), 600, 510, 255, 0};
        tbl[6] = '{pk(0, 0, 0, 0, 0, 0, 0, 0, 255), 509, 510, 255, 1};
        tbl[7] = '{pk(0, 0, 10, 0, 0, 0, 0, 0, 0), 0, 20, 20, 1};
        tbl[8] = '{pk(0, 0, 0, 0, 0, 255, 0, 255, 255), 2000, 1530, 255, 0};
        tbl[9] = '{pk(0, 0, 0, 0, 0, 255, 0, 255, 255), 1529, 1530, 255, 1};

        {w00, w01, w02, w10, w11, w12, w20, w21, w22} = '0;
        thresh_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // each table entry fills one whole frame, frames back-to-back
        for (int i = 0; i < 10; i++)
            for (int k = 0; k < OPF; k++)
                drive(tbl[i].px, tbl[i].thr, tbl[i].mag, tbl[i].pix, tbl[i].edg, 1'b1);

        drive(v_px, 128, 1020, 255, 1, 1'b1);
        drive(f_px, 128, 0, 0, 0, 1'b1);
        drive(v_px, 128, 1020, 255, 1, 1'b1);
        drive(f_px, 128, 0, 0, 0, 1'b1);
        for (int k = 0; k < OPF; k++) drive(v_px, 128, 1020, 255, 1, 1'b1);
        idle(3);

        // threshold shadow: mid-frame change ignored, next frame load applies at once
        drive(v_px, 2000, 1020, 255, 0, 1'b1);
        drive(v_px, 2000, 1020, 255, 0, 1'b1);
        drive(v_px, 0, 1020, 255, 0, 1'b1);
        drive(v_px, 0, 1020, 255, 0, 1'b1);
        for (int k = 0; k < OPF; k++) drive(v_px, 0, 1020, 255, 1, 1'b1);

        for (int n = 0; n < 24; n++) begin
            drive_m(pk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                       $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                       $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)),
                    $urandom_range(0, 2047));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(6);

        // reset with two windows in flight mid-frame
        drive(v_px, 128, 1020, 255, 1, 1'b1);
        idle(5);
        drive(f_px, 128, 0, 0, 0, 1'b0);
        drive(f_px, 128, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_idx = 0;
        m_acc = 0;
        chk_zero("midreset");
        idle(4);
        for (int k = 0; k < OPF; k++) drive(v_px, 128, 1020, 255, 1, 1'b1);
        idle(2);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        chk("drain_queue", q.size(), 0);
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
